// File: rtl/regfile_bubble_sorter.sv
// In-place bubble sorter driving the read and write ports of a register file.
// One adjacent pair is compared per step; a clean pass ends the sort early.
module regfile_bubble_sorter #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ASCEND = 1,
    parameter int CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  Swap_Count,
    output logic [ADDR_W-1:0] R_Addr,
    output logic              R_en,
    input  logic [DATA_W-1:0] R_Data,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              W_en,
    output logic [DATA_W-1:0] W_Data
);

    typedef enum logic [2:0] {
        IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PASS = ADDR_W'(DEPTH - 2);

    state_t            r_state;
    state_t            w_nextState;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_pass;
    logic              r_swapped;
    logic [CNT_W-1:0]  r_swapCnt;

    logic [ADDR_W-1:0] w_lastI;
    logic              w_atLast;
    logic              w_finish;
    logic              w_swap;

    // The inner loop shrinks by one each pass: the tail is already in place.
    assign w_lastI  = LAST_PASS - r_pass;
    assign w_atLast = (r_i == w_lastI);
    assign w_finish = w_atLast && (!r_swapped || (r_pass == LAST_PASS));
    assign w_swap   = (ASCEND != 0) ? (r_a > r_b) : (r_a < r_b);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (Start) w_nextState = RD_A;
            RD_A:    w_nextState = RD_B;
            RD_B:    w_nextState = CMP;
            CMP:     w_nextState = w_swap ? WR_A : NEXT;
            WR_A:    w_nextState = WR_B;
            WR_B:    w_nextState = NEXT;
            NEXT:    w_nextState = w_finish ? DONE : RD_A;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_i       <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
            r_swapCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_i       <= '0;
                        r_pass    <= '0;
                        r_swapped <= 1'b0;
                        r_swapCnt <= '0;
                    end
                end
                RD_A: r_a <= R_Data;
                RD_B: r_b <= R_Data;
                WR_B: begin
                    r_swapped <= 1'b1;
                    if (r_swapCnt != '1) r_swapCnt <= r_swapCnt + CNT_W'(1);
                end
                NEXT: begin
                    if (!w_atLast) begin
                        r_i <= r_i + ADDR_W'(1);
                    end else if (!w_finish) begin
                        r_pass    <= r_pass + ADDR_W'(1);
                        r_i       <= '0;
                        r_swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Port decode depends only on the registered state and datapath registers.
    always_comb begin
        R_en   = 1'b0;
        R_Addr = '0;
        W_en   = 1'b0;
        W_Addr = '0;
        W_Data = '0;
        case (r_state)
            RD_A: begin R_en = 1'b1; R_Addr = r_i; end
            RD_B: begin R_en = 1'b1; R_Addr = r_i + ADDR_W'(1); end
            WR_A: begin W_en = 1'b1; W_Addr = r_i; W_Data = r_b; end
            WR_B: begin W_en = 1'b1; W_Addr = r_i + ADDR_W'(1); W_Data = r_a; end
            default: ;
        endcase
    end

    assign Busy       = (r_state != IDLE);
    assign Done       = (r_state == DONE);
    assign Swap_Count = r_swapCnt;

endmodule

// File: tb/tb_regfile_bubble_sorter.sv
// Bench for regfile_bubble_sorter: an ascending and a descending instance, each
// attached to its own register-file model, checked against a reference sort.
module tb_regfile_bubble_sorter;

    localparam int D = 16;
    typedef logic [7:0] arr_t [D];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN;
    logic start0, start1;
    logic busy0, done0, ren0, wen0;
    logic busy1, done1, ren1, wen1;
    logic [7:0] swap0, swap1, wdata0, wdata1;
    logic [3:0] raddr0, waddr0, raddr1, waddr1;
    wire  [7:0] rdata0;
    wire  [7:0] rdata1;

    arr_t mem0, mem1, pre0, pre1;
    logic load0, load1;

    int total;
    int bad;

    assign rdata0 = ren0 ? mem0[raddr0] : 8'bz;
    assign rdata1 = ren1 ? mem1[raddr1] : 8'bz;

    // Register-file models: bulk preload, otherwise one write per cycle.
    always @(posedge clk) begin
        if (load0) mem0 <= pre0;
        else if (wen0) mem0[waddr0] <= wdata0;
        if (load1) mem1 <= pre1;
        else if (wen1) mem1[waddr1] <= wdata1;
    end

    regfile_bubble_sorter #(.DEPTH(16), .DATA_W(8), .ADDR_W(4), .ASCEND(1), .CNT_W(8)) u_asc (
        .Clk(clk), .Rst(rstN), .Start(start0), .Busy(busy0), .Done(done0),
        .Swap_Count(swap0), .R_Addr(raddr0), .R_en(ren0), .R_Data(rdata0),
        .W_Addr(waddr0), .W_en(wen0), .W_Data(wdata0)
    );

    regfile_bubble_sorter #(.DEPTH(16), .DATA_W(8), .ADDR_W(4), .ASCEND(0), .CNT_W(8)) u_desc (
        .Clk(clk), .Rst(rstN), .Start(start1), .Busy(busy1), .Done(done1),
        .Swap_Count(swap1), .R_Addr(raddr1), .R_en(ren1), .R_Data(rdata1),
        .W_Addr(waddr1), .W_en(wen1), .W_Data(wdata1)
    );

    arr_t preload;
    arr_t preAsc;
    arr_t preDesc;

    // Reference: sorted order from a queue sort, swaps as inversion count,
    // cycles from counting compares/swaps over the pass structure.
    task automatic model(input arr_t a, input bit asc, output arr_t sorted,
                         output int swaps, output int cycles);
        int   q[$];
        arr_t w;
        int   pass;
        bit   sw;
        logic [7:0] t;
        foreach (a[k]) q.push_back(int'(a[k]));
        q.sort();
        if (!asc) q.reverse();
        foreach (sorted[k]) sorted[k] = 8'(q[k]);
        swaps = 0;
        for (int x = 0; x < D; x++)
            for (int y = x + 1; y < D; y++)
                if (asc ? (a[x] > a[y]) : (a[x] < a[y])) swaps++;
        w = a;
        pass = 0;
        cycles = 1;
        forever begin
            sw = 0;
            for (int j = 0; j <= D - 2 - pass; j++) begin
                cycles += 4;
                if (asc ? (w[j] > w[j+1]) : (w[j] < w[j+1])) begin
                    t = w[j]; w[j] = w[j+1]; w[j+1] = t;
                    cycles += 2;
                    sw = 1;
                end
            end
            if (!sw || pass == D - 2) break;
            pass++;
        end
    endtask

    task automatic load_mem(input int which, input arr_t vals);
        @(negedge clk);
        if (which == 0) begin pre0 = vals; load0 = 1'b1; end
        else begin pre1 = vals; load1 = 1'b1; end
        @(negedge clk);
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start0 = v;
        else start1 = v;
    endtask

    task automatic run_sort(input int which, input bit inject, output int busyCyc,
                            output int doneCnt, output int wenCnt, output int overlap,
                            output bit timeout);
        logic b, dn, we, re, prevWe;
        busyCyc = 0; doneCnt = 0; wenCnt = 0; overlap = 0; timeout = 1; prevWe = 0;
        @(negedge clk);
        set_start(which, 1'b1);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            set_start(which, 1'b0);
            b  = (which == 0) ? busy0 : busy1;
            dn = (which == 0) ? done0 : done1;
            we = (which == 0) ? wen0  : wen1;
            re = (which == 0) ? ren0  : ren1;
            if (!b) begin timeout = 0; break; end
            busyCyc++;
            if (dn) doneCnt++;
            if (we) wenCnt++;
            if (we && re) overlap++;
            if (inject && ((we && !prevWe) || (c % 17 == 5))) set_start(which, 1'b1);
            prevWe = we;
        end
        set_start(which, 1'b0);
        total++;
        if (timeout) begin
            bad++;
            $display("[TB] FAIL timeout: sort on instance %0d did not finish within budget", which);
        end
    endtask

    task automatic check_contents(input string name, input arr_t act, input arr_t exp);
        int firstBad;
        firstBad = -1;
        for (int k = D - 1; k >= 0; k--) if (act[k] !== exp[k]) firstBad = k;
        total++;
        if (firstBad >= 0) begin
            bad++;
            $display("[TB] FAIL %s: entry %0d is %0d, required %0d", name, firstBad,
                     act[firstBad], exp[firstBad]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy0, done0, ren0, wen0, swap0, raddr0, waddr0, wdata0} !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h, required 0",
                     {busy0, done0, ren0, wen0, swap0, raddr0, waddr0, wdata0});
        end
        rstN = 1'b1;
        @(negedge clk);
        total++;
        if ({busy0, done0, ren0, wen0, busy1, done1, ren1, wen1} !== 8'd0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset: got %b, required 0",
                     {busy0, done0, ren0, wen0, busy1, done1, ren1, wen1});
        end
    endtask

    task automatic test_preload();
        int bc, dc, wc, ov; bit to;
        load_mem(0, preload);
        run_sort(0, 0, bc, dc, wc, ov, to);
        check_contents("preload_sorted", mem0, preAsc);
        check_int("preload_swaps", int'(swap0), 54);
        check_int("preload_done_pulses", dc, 1);
        check_int("preload_busy_low", int'(busy0), 0);
        check_int("preload_rw_overlap", ov, 0);
    endtask

    task automatic test_sorted();
        int bc, dc, wc, ov; bit to;
        load_mem(0, preAsc);
        run_sort(0, 0, bc, dc, wc, ov, to);
        check_int("sorted_swaps", int'(swap0), 0);
        check_int("sorted_busy_cycles", bc, 61);
        check_int("sorted_wen_count", wc, 0);
        check_contents("sorted_unchanged", mem0, preAsc);
    endtask

    task automatic test_all_equal();
        int bc, dc, wc, ov; bit to;
        arr_t sevens;
        foreach (sevens[k]) sevens[k] = 8'd7;
        load_mem(0, sevens);
        run_sort(0, 0, bc, dc, wc, ov, to);
        check_int("equal_swaps", int'(swap0), 0);
        check_int("equal_busy_cycles", bc, 61);
        check_int("equal_done_pulses", dc, 1);
        check_contents("equal_unchanged", mem0, sevens);
    endtask

    task automatic test_descending();
        int bc, dc, wc, ov; bit to;
        load_mem(1, preload);
        run_sort(1, 0, bc, dc, wc, ov, to);
        check_contents("desc_sorted", mem1, preDesc);
        check_int("desc_swaps", int'(swap1), 66);
        check_int("desc_done_pulses", dc, 1);
    endtask

    task automatic test_random();
        int bc, dc, wc, ov, expSw, expCyc; bit to;
        arr_t a, expArr;
        for (int it = 0; it < 6; it++) begin
            foreach (a[k]) a[k] = (it % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            for (int which = 0; which < 2; which++) begin
                model(a, (which == 0), expArr, expSw, expCyc);
                load_mem(which, a);
                run_sort(which, 0, bc, dc, wc, ov, to);
                check_contents("random_sorted", (which == 0) ? mem0 : mem1, expArr);
                check_int("random_swaps", (which == 0) ? int'(swap0) : int'(swap1), expSw);
                check_int("random_busy_cycles", bc, expCyc);
                check_int("random_wen_count", wc, 2 * expSw);
                check_int("random_rw_overlap", ov, 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc, wc, ov, expSw, expCyc; bit to;
        arr_t expArr;
        model(preload, 1'b1, expArr, expSw, expCyc);
        load_mem(0, preload);
        run_sort(0, 1, bc, dc, wc, ov, to);
        check_contents("restart_sorted", mem0, preAsc);
        check_int("restart_swaps", int'(swap0), 54);
        check_int("restart_busy_cycles", bc, expCyc);
        check_int("restart_done_pulses", dc, 1);
    endtask

    task automatic test_reset_mid();
        int bc, dc, wc, ov, expSw, expCyc; bit to, found;
        logic prevWe;
        arr_t snap, expArr;
        load_mem(0, preload);
        @(negedge clk);
        start0 = 1'b1;
        found = 0;
        prevWe = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (wen0 && prevWe) begin found = 1; break; end
            prevWe = wen0;
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL reset_mid_find_wrb: WR_B cycle not reached");
        end
        rstN = 1'b0;
        #1;
        total++;
        if ({busy0, ren0, wen0, done0, swap0} !== 12'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_outputs: got %h, required 0",
                     {busy0, ren0, wen0, done0, swap0});
        end
        @(negedge clk);
        check_int("reset_mid_held_busy", int'(busy0), 0);
        rstN = 1'b1;
        @(negedge clk);
        snap = mem0;
        model(snap, 1'b1, expArr, expSw, expCyc);
        run_sort(0, 0, bc, dc, wc, ov, to);
        check_contents("reset_mid_resort", mem0, expArr);
        check_int("reset_mid_resort_swaps", int'(swap0), expSw);
        check_int("reset_mid_resort_cycles", bc, expCyc);
    endtask

    initial begin
        total = 0;
        bad = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        load0 = 1'b0;
        load1 = 1'b0;
        preload = '{8'd48, 8'd53, 8'd68, 8'd57, 8'd55, 8'd59, 8'd40, 8'd49,
                    8'd31, 8'd38, 8'd54, 8'd50, 8'd63, 8'd58, 8'd70, 8'd51};
        preAsc  = '{8'd31, 8'd38, 8'd40, 8'd48, 8'd49, 8'd50, 8'd51, 8'd53,
                    8'd54, 8'd55, 8'd57, 8'd58, 8'd59, 8'd63, 8'd68, 8'd70};
        preDesc = '{8'd70, 8'd68, 8'd63, 8'd59, 8'd58, 8'd57, 8'd55, 8'd54,
                    8'd53, 8'd51, 8'd50, 8'd49, 8'd48, 8'd40, 8'd38, 8'd31};
        test_reset();
        test_preload();
        test_sorted();
        test_all_equal();
        test_descending();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
